// File: rtl/div_pool_unit_if.sv
// Command/status bundle between the MulDiv issue logic and div_pool_unit.
// The unit sits on the slave modport; the issuing pipe drives the master side.
interface div_pool_unit_if #(
    parameter int DATA_WIDTH   = 32,
    parameter int NUM_DIV      = 2,
    parameter int AL_PTR_WIDTH = 6,
    parameter int ID_WIDTH     = (NUM_DIV > 1) ? $clog2(NUM_DIV) : 1
);
    logic                    acquire;
    logic [AL_PTR_WIDTH-1:0] acquireAlPtr;
    logic                    acquireGrant;
    logic [ID_WIDTH-1:0]     acquireId;
    logic                    req;
    logic [ID_WIDTH-1:0]     reqId;
    logic [1:0]              reqCode;
    logic [DATA_WIDTH-1:0]   opA;
    logic [DATA_WIDTH-1:0]   opB;
    logic                    releaseEn;   // 'release' is a reserved word
    logic [ID_WIDTH-1:0]     releaseId;
    logic [ID_WIDTH-1:0]     readId;
    logic [DATA_WIDTH-1:0]   dataOut;
    logic                    flushValid;
    logic                    flushAll;
    logic [AL_PTR_WIDTH-1:0] flushHeadPtr;
    logic [AL_PTR_WIDTH-1:0] flushTailPtr;
    logic [NUM_DIV-1:0]      divFree;
    logic [NUM_DIV-1:0]      divReserved;
    logic [NUM_DIV-1:0]      divBusy;
    logic [NUM_DIV-1:0]      divFinished;

    modport master (
        output acquire, acquireAlPtr, req, reqId, reqCode, opA, opB,
               releaseEn, releaseId, readId, flushValid, flushAll,
               flushHeadPtr, flushTailPtr,
        input  acquireGrant, acquireId, dataOut,
               divFree, divReserved, divBusy, divFinished
    );

    modport slave (
        input  acquire, acquireAlPtr, req, reqId, reqCode, opA, opB,
               releaseEn, releaseId, readId, flushValid, flushAll,
               flushHeadPtr, flushTailPtr,
        output acquireGrant, acquireId, dataOut,
               divFree, divReserved, divBusy, divFinished
    );
endinterface

// File: rtl/div_pool_unit.sv
// Pool of NUM_DIV restoring radix-2 dividers with grant/req/release and active-list flush.
// Optional feature: DIV_POOL_SPECIAL_EARLY_OUT_EN lets div-by-zero and signed overflow finish early.
module div_pool_unit #(
    parameter int DATA_WIDTH   = 32,
    parameter int NUM_DIV      = 2,
    parameter int AL_PTR_WIDTH = 6,
    parameter int ID_WIDTH     = (NUM_DIV > 1) ? $clog2(NUM_DIV) : 1
) (
    input logic          clk,
    input logic          rst,
    div_pool_unit_if.slave bus
);
    localparam int CNT_W = $clog2(DATA_WIDTH);

    typedef enum logic [1:0] {FREE, RESERVED, PROCESSING, WAITING} phase_t;

    phase_t [NUM_DIV-1:0]                 phase_w;
    logic   [NUM_DIV-1:0][DATA_WIDTH-1:0] res_w;

    logic                  grant;
    logic [ID_WIDTH-1:0]   grant_id;
    logic                  sgn, a_neg, b_neg, divz, ovf;
    logic [DATA_WIDTH-1:0] a_mag, b_mag, spc_res;

    function automatic logic in_range(input logic [AL_PTR_WIDTH-1:0] p,
                                      input logic [AL_PTR_WIDTH-1:0] head,
                                      input logic [AL_PTR_WIDTH-1:0] tail);
        if (head < tail)      return (p >= head) && (p < tail);
        else if (head > tail) return (p >= head) || (p < tail);
        else                  return 1'b0;
    endfunction

    // Lowest-index FREE divider wins; a flush cycle never grants.
    always_comb begin
        grant    = 1'b0;
        grant_id = '0;
        for (int i = NUM_DIV - 1; i >= 0; i--) begin
            if (phase_w[i] == FREE) begin
                grant    = 1'b1;
                grant_id = ID_WIDTH'(i);
            end
        end
        if (!bus.acquire || bus.flushValid) begin
            grant    = 1'b0;
            grant_id = '0;
        end
    end

    assign bus.acquireGrant = grant;
    assign bus.acquireId    = grant_id;

    // Operand preparation is shared: at most one req is accepted per cycle.
    always_comb begin
        sgn   = ~bus.reqCode[0];
        a_neg = sgn & bus.opA[DATA_WIDTH-1];
        b_neg = sgn & bus.opB[DATA_WIDTH-1];
        a_mag = a_neg ? -bus.opA : bus.opA;
        b_mag = b_neg ? -bus.opB : bus.opB;
        divz  = (bus.opB == '0);
        ovf   = sgn && (bus.opA == {1'b1, {(DATA_WIDTH-1){1'b0}}}) && (bus.opB == '1);
        if (divz) spc_res = bus.reqCode[1] ? bus.opA : '1;
        else      spc_res = bus.reqCode[1] ? '0 : {1'b1, {(DATA_WIDTH-1){1'b0}}};
    end

    for (genvar i = 0; i < NUM_DIV; i++) begin : g_div
        phase_t                  phase_q;
        logic [AL_PTR_WIDTH-1:0] ptr_q;
        logic [CNT_W-1:0]        cnt_q;
        logic [DATA_WIDTH-1:0]   quo_q, rem_q, dvs_q, res_q, spc_q;
        logic                    negq_q, negr_q, selrem_q, special_q;
        logic [DATA_WIDTH-1:0]   quo_d, rem_d, fin_d;
        logic [DATA_WIDTH:0]     shf, diff;
        logic                    flush_hit;

        assign flush_hit = bus.flushValid && (phase_q != FREE) &&
                           (bus.flushAll || in_range(ptr_q, bus.flushHeadPtr, bus.flushTailPtr));

        // One restoring step: shift the next dividend bit in, subtract if it fits.
        always_comb begin
            shf  = {rem_q, quo_q[DATA_WIDTH-1]};
            diff = shf - {1'b0, dvs_q};
            if (shf >= {1'b0, dvs_q}) begin
                rem_d = diff[DATA_WIDTH-1:0];
                quo_d = {quo_q[DATA_WIDTH-2:0], 1'b1};
            end else begin
                rem_d = shf[DATA_WIDTH-1:0];
                quo_d = {quo_q[DATA_WIDTH-2:0], 1'b0};
            end
            if (special_q)     fin_d = spc_q;
            else if (selrem_q) fin_d = negr_q ? -rem_d : rem_d;
            else               fin_d = negq_q ? -quo_d : quo_d;
        end

        always_ff @(posedge clk) begin
            if (rst) begin
                phase_q   <= FREE;
                ptr_q     <= '0;
                cnt_q     <= '0;
                quo_q     <= '0;
                rem_q     <= '0;
                dvs_q     <= '0;
                res_q     <= '0;
                spc_q     <= '0;
                negq_q    <= 1'b0;
                negr_q    <= 1'b0;
                selrem_q  <= 1'b0;
                special_q <= 1'b0;
            end else if (flush_hit) begin
                phase_q <= FREE;
                cnt_q   <= '0;
            end else begin
                case (phase_q)
                    FREE: if (grant && grant_id == ID_WIDTH'(i)) begin
                        phase_q <= RESERVED;
                        ptr_q   <= bus.acquireAlPtr;
                    end
                    RESERVED: if (bus.req && bus.reqId == ID_WIDTH'(i)) begin
                        phase_q   <= PROCESSING;
                        quo_q     <= a_mag;
                        rem_q     <= '0;
                        dvs_q     <= b_mag;
                        negq_q    <= a_neg ^ b_neg;
                        negr_q    <= a_neg;
                        selrem_q  <= bus.reqCode[1];
                        special_q <= divz | ovf;
                        spc_q     <= spc_res;
`ifdef DIV_POOL_SPECIAL_EARLY_OUT_EN
                        cnt_q     <= (divz | ovf) ? CNT_W'(DATA_WIDTH - 1) : '0;
`else
                        cnt_q     <= '0;
`endif
                    end
                    PROCESSING: begin
                        quo_q <= quo_d;
                        rem_q <= rem_d;
                        cnt_q <= cnt_q + 1'b1;
                        if (cnt_q == CNT_W'(DATA_WIDTH - 1)) begin
                            phase_q <= WAITING;
                            res_q   <= fin_d;
                        end
                    end
                    WAITING: if (bus.releaseEn && bus.releaseId == ID_WIDTH'(i)) phase_q <= FREE;
                    default: phase_q <= FREE;
                endcase
            end
        end

        assign phase_w[i]         = phase_q;
        assign res_w[i]           = res_q;
        assign bus.divFree[i]     = (phase_q == FREE);
        assign bus.divReserved[i] = (phase_q == RESERVED);
        assign bus.divBusy[i]     = (phase_q == PROCESSING);
        assign bus.divFinished[i] = (phase_q == WAITING);
    end

    always_comb begin
        bus.dataOut = '0;
        for (int i = 0; i < NUM_DIV; i++)
            if (bus.readId == ID_WIDTH'(i)) bus.dataOut = res_w[i];
    end
endmodule

// File: tb/tb_div_pool_unit.sv
// Directed bench for div_pool_unit with a behavioural pool model checked every cycle.
module tb_div_pool_unit;
    localparam int W     = 32;
    localparam int N     = 2;
    localparam int P     = 6;
    localparam int IW    = 1;
    localparam int LNORM = W + 1;
`ifdef DIV_POOL_SPECIAL_EARLY_OUT_EN
    localparam int LSPC  = 2;
`else
    localparam int LSPC  = W + 1;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    div_pool_unit_if #(.DATA_WIDTH(W), .NUM_DIV(N), .AL_PTR_WIDTH(P), .ID_WIDTH(IW)) bus ();
    div_pool_unit #(.DATA_WIDTH(W), .NUM_DIV(N), .AL_PTR_WIDTH(P), .ID_WIDTH(IW)) dut (
        .clk(clk), .rst(rst), .bus(bus));

    int total = 0;
    int bad   = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    // Architectural result of one op, straight from the ISA rules.
    function automatic logic [31:0] ref_div(input logic [1:0] code, input logic [31:0] a,
                                            input logic [31:0] b);
        logic [31:0] q, r;
        if (b == 0) begin
            q = '1; r = a;
        end else if (!code[0] && a == 32'h80000000 && b == 32'hFFFFFFFF) begin
            q = a; r = 0;
        end else if (!code[0]) begin
            q = $signed(a) / $signed(b);
            r = $signed(a) % $signed(b);
        end else begin
            q = a / b;
            r = a % b;
        end
        return code[1] ? r : q;
    endfunction

    function automatic int op_lat(input logic [1:0] code, input logic [31:0] a, input logic [31:0] b);
        if (b == 0 || (!code[0] && a == 32'h80000000 && b == 32'hFFFFFFFF)) return LSPC;
        return LNORM;
    endfunction

    // Model: 0=free, 1=reserved, 2=started (busy until m_done, then finished).
    int          m_ph   [N];
    int          m_ptr  [N];
    logic [31:0] m_res  [N];
    longint      m_done [N];
    longint      cyc = 0;

    function automatic int model_grant();
        if (!bus.acquire || bus.flushValid) return -1;
        for (int i = 0; i < N; i++) if (m_ph[i] == 0) return i;
        return -1;
    endfunction

    // Pointer in [head,tail) on the circular active list: distance from head below range length.
    function automatic bit in_rng(input int p);
        int d, s;
        d = (p - int'(bus.flushHeadPtr)) & ((1 << P) - 1);
        s = (int'(bus.flushTailPtr) - int'(bus.flushHeadPtr)) & ((1 << P) - 1);
        return d < s;
    endfunction

    always @(posedge clk) begin
        int g;
        if (rst) begin
            for (int i = 0; i < N; i++) begin m_ph[i] = 0; m_ptr[i] = 0; m_res[i] = 0; m_done[i] = 0; end
        end else begin
            g = model_grant();
            for (int i = 0; i < N; i++) begin
                if (m_ph[i] != 0 && bus.flushValid && (bus.flushAll || in_rng(m_ptr[i]))) m_ph[i] = 0;
                else if (m_ph[i] == 0 && g == i) begin m_ph[i] = 1; m_ptr[i] = int'(bus.acquireAlPtr); end
                else if (m_ph[i] == 1 && bus.req && int'(bus.reqId) == i) begin
                    m_ph[i]   = 2;
                    m_res[i]  = ref_div(bus.reqCode, bus.opA, bus.opB);
                    m_done[i] = cyc + op_lat(bus.reqCode, bus.opA, bus.opB);
                end else if (m_ph[i] == 2 && cyc >= m_done[i] && bus.releaseEn && int'(bus.releaseId) == i)
                    m_ph[i] = 0;
            end
        end
        cyc++;
    end

    always @(negedge clk) begin
        logic [N-1:0] ef, er, eb, ed;
        int g;
        if (!rst) begin
            for (int i = 0; i < N; i++) begin
                ef[i] = (m_ph[i] == 0);
                er[i] = (m_ph[i] == 1);
                eb[i] = (m_ph[i] == 2) && (cyc < m_done[i]);
                ed[i] = (m_ph[i] == 2) && (cyc >= m_done[i]);
            end
            chk("divFree", bus.divFree, ef);
            chk("divReserved", bus.divReserved, er);
            chk("divBusy", bus.divBusy, eb);
            chk("divFinished", bus.divFinished, ed);
            g = model_grant();
            chk("acquireGrant", bus.acquireGrant, g >= 0);
            if (g >= 0) chk("acquireId", bus.acquireId, g);
            if (ed[bus.readId]) chk("dataOut", bus.dataOut, m_res[bus.readId]);
        end
    end

    task automatic clr();
        bus.acquire = 0; bus.acquireAlPtr = 0; bus.req = 0; bus.reqId = 0; bus.reqCode = 0;
        bus.opA = 0; bus.opB = 0; bus.releaseEn = 0; bus.releaseId = 0;
        bus.flushValid = 0; bus.flushAll = 0; bus.flushHeadPtr = 0; bus.flushTailPtr = 0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic acq(input int ptr, input logic expg, input int expid);
        clr();
        bus.acquire = 1; bus.acquireAlPtr = P'(ptr);
        #1;
        chk("acqGrant", bus.acquireGrant, expg);
        if (expg) chk("acqId", bus.acquireId, expid);
        tick(); clr();
    endtask

    task automatic run_op(input int id, input logic [1:0] code, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp, input int lat, input bit stray);
        clr();
        bus.readId = IW'(id);
        bus.req = 1; bus.reqId = IW'(id); bus.reqCode = code; bus.opA = a; bus.opB = b;
        tick(); clr();
        if (stray) begin bus.releaseEn = 1; bus.releaseId = IW'(id); end
        for (int k = 1; k < lat; k++) begin
            chk("opBusy", bus.divBusy[id], 1);
            tick(); clr();
        end
        chk("opDone", bus.divFinished[id], 1);
        chk("opResult", bus.dataOut, exp);
        bus.releaseEn = 1; bus.releaseId = IW'(id);
        tick(); clr();
        chk("opFreed", bus.divFree[id], 1);
    endtask

    initial begin
        clr();
        bus.readId = 0;
        repeat (3) @(posedge clk);
        #1 rst = 0;
        chk("rstFree", bus.divFree, 2'b11);
        chk("rstReserved", bus.divReserved, 2'b00);
        chk("rstBusy", bus.divBusy, 2'b00);
        chk("rstFinished", bus.divFinished, 2'b00);

        chk("refDiv", ref_div(2'd0, 32'hFFFFFFF9, 32'd2), 32'hFFFFFFFD);
        chk("refRem", ref_div(2'd2, 32'hFFFFFFF9, 32'd2), 32'hFFFFFFFF);
        chk("refDivZero", ref_div(2'd1, 32'd5, 32'd0), 32'hFFFFFFFF);
        chk("refOvf", ref_div(2'd0, 32'h80000000, 32'hFFFFFFFF), 32'h80000000);

        acq(5, 1, 0);
        chk("resv0", bus.divReserved, 2'b01);
        acq(6, 1, 1);
        acq(7, 0, 0);

        run_op(0, 2'd0, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD, LNORM, 1);
        clr(); bus.req = 1; bus.reqId = 0; bus.opA = 9; bus.opB = 3;
        tick(); clr();
        chk("strayReq", bus.divFree[0], 1);
        run_op(1, 2'd2, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, LNORM, 0);

        acq(8, 1, 0); run_op(0, 2'd1, 32'd5, 32'd0, 32'hFFFFFFFF, LSPC, 1);
        acq(8, 1, 0); run_op(0, 2'd0, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, LSPC, 0);
        acq(8, 1, 0); run_op(0, 2'd3, 32'd100, 32'd7, 32'd2, LNORM, 0);
        acq(8, 1, 0); run_op(0, 2'd0, 32'd100, 32'hFFFFFFF9, 32'hFFFFFFF2, LNORM, 0);
        acq(8, 1, 0); run_op(0, 2'd2, 32'hFFFFFFFB, 32'd0, 32'hFFFFFFFB, LSPC, 0);

        acq(60, 1, 0);
        acq(3, 1, 1);
        clr(); bus.flushValid = 1; bus.flushHeadPtr = 58; bus.flushTailPtr = 2;
        tick(); clr();
        chk("wrapFlushed", bus.divFree, 2'b01);
        chk("wrapKept", bus.divReserved, 2'b10);
        acq(10, 1, 0);
        clr(); bus.flushValid = 1; bus.flushHeadPtr = 10; bus.flushTailPtr = 10;
        tick(); clr();
        chk("emptyFlush", bus.divReserved, 2'b11);

        clr(); bus.req = 1; bus.reqId = 0; bus.reqCode = 2'd1; bus.opA = 9; bus.opB = 3;
        tick(); clr();
        repeat (LNORM - 1) tick();
        chk("scWaiting", bus.divFinished, 2'b01);
        bus.releaseEn = 1; bus.releaseId = 0; bus.acquire = 1; bus.acquireAlPtr = 20;
        bus.flushValid = 1; bus.flushHeadPtr = 3; bus.flushTailPtr = 4;
        #1;
        chk("scNoGrant", bus.acquireGrant, 0);
        tick(); clr();
        chk("scAllFree", bus.divFree, 2'b11);
        acq(21, 1, 0);

        acq(22, 1, 1);
        clr(); bus.req = 1; bus.reqId = 1; bus.opA = 1000; bus.opB = 3;
        tick(); clr();
        repeat (5) tick();
        chk("preFlushBusy", bus.divBusy, 2'b10);
        clr(); bus.flushValid = 1; bus.flushAll = 1;
        tick(); clr();
        chk("flushAll", bus.divFree, 2'b11);
        repeat (3) tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
